// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply sequencer for the EX stage; holds the pipeline until the product is ready.
// Optional early termination is enabled by defining MUL_SEQ_EARLY_TERM_EN.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic             w_last;

  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

  // Early exit once no multiplier bits remain; the product is already final.
`ifdef MUL_SEQ_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_W'(WIDTH-1)) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH-1));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (req_i && !flush_i) begin
            r_mcand  <= op_a_i;
            r_mplier <= op_b_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              r_result <= w_acc_next;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so the downstream stage latches result_o on the done edge.
  assign stall_o  = !rst_i && (((r_state == S_IDLE) && req_i && !flush_i) || (r_state == S_RUN));
  assign busy_o   = (r_state == S_RUN);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed and random multiplies against a product/latency model.
module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic             req_i;
  logic             flush_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  int vectors;
  int miscompares;
  logic [WIDTH-1:0] lastResult;

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .flush_i (flush_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: product is the truncated arithmetic product; RUN length depends only on op_b.
  function automatic logic [WIDTH-1:0] refProduct(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return full[WIDTH-1:0];
  endfunction

  function automatic int refRuns(logic [WIDTH-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int n;
    logic [WIDTH-1:0] v;
    n = 0;
    v = b;
    while (v != 0) begin
      v = v / 2;
      n++;
    end
    return (n < 1) ? 1 : n;
`else
    return WIDTH;
`endif
  endfunction

  task automatic checkOutput(string tag, logic [WIDTH-1:0] obs, logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one multiply from the IDLE cycle through DONE; leaves req_i high when keepReq is set.
  task automatic applyStimulus(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit keepReq);
    int runs;
    int stalls;
    @(negedge clk_i);
    checkOutput("idle_busy", {31'd0, busy_o}, 32'd0);
    req_i  = 1'b1;
    op_a_i = a;
    op_b_i = b;
    #1;
    checkOutput("req_stall", {31'd0, stall_o}, 32'd1);
    stalls = 1;
    runs   = 0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      @(negedge clk_i);
      op_a_i = $urandom;
      op_b_i = $urandom;
      if (!busy_o) break;
      runs++;
      if (stall_o) stalls++;
    end
    checkOutput("run_cycles", runs, refRuns(b));
    checkOutput("stall_cycles", stalls, refRuns(b) + 1);
    checkOutput("done_pulse", {31'd0, done_o}, 32'd1);
    checkOutput("done_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("result", result_o, refProduct(a, b));
    lastResult = refProduct(a, b);
    if (!keepReq) req_i = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bit sawDone;
    vectors     = 0;
    miscompares = 0;
    lastResult  = '0;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    flush_i = 1'b0;
    op_a_i  = '0;
    op_b_i  = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
    rst_i = 1'b0;

    applyStimulus(32'd3, 32'd5, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b0);

    applyStimulus(32'd7, 32'd6, 1'b1);
    applyStimulus(32'h1234, 32'h10, 1'b0);
    @(negedge clk_i);
    checkOutput("b2b_done_low", {31'd0, done_o}, 32'd0);

    applyStimulus(32'd0, 32'd0, 1'b0);
    applyStimulus(32'd5, 32'd8, 1'b0);
    applyStimulus(32'd1, 32'h8000_0000, 1'b0);

    // Flush and request together in IDLE must not capture.
    @(negedge clk_i);
    req_i   = 1'b1;
    flush_i = 1'b1;
    #1;
    checkOutput("flush_req_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    checkOutput("flush_req_busy", {31'd0, busy_o}, 32'd0);
    req_i   = 1'b0;
    flush_i = 1'b0;

    // Flush at RUN cycle 10 of 100*100.
    @(negedge clk_i);
    req_i  = 1'b1;
    op_a_i = 32'd100;
    op_b_i = 32'd100;
    repeat (10) @(negedge clk_i);
    checkOutput("flush_in_run", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    req_i   = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flush_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("flush_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("flush_result", result_o, lastResult);
    sawDone = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk_i);
      if (done_o) sawDone = 1'b1;
    end
    checkOutput("flush_no_done", {31'd0, sawDone}, 32'd0);

    // Asynchronous reset between edges while in RUN.
    @(negedge clk_i);
    req_i  = 1'b1;
    op_a_i = 32'd11;
    op_b_i = 32'd13;
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("arst_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("arst_done", {31'd0, done_o}, 32'd0);
    checkOutput("arst_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = 1'b0;
    applyStimulus(32'd9, 32'd9, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? $urandom : (32'd1 << $urandom_range(0, 31));
      applyStimulus(ra, rb, 1'b0);
    end

    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative shift-add multiply sequencer that takes the mul operation (low WIDTH bits of the product) off the single-cycle EX path.
- Sits beside the ALU in the EX stage. Accepts an operand pair from the EX stage, runs one add/shift step per cycle, and holds the pipeline via stall_o until the product is ready.
- Returns the product to EX with a one-cycle done_o strobe.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count in full mode.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- req_i  input  1  EX stage holds a mul instruction; level, held until done_o.
- flush_i  input  1  pipeline flush; aborts any in-flight multiply.
- op_a_i  input  WIDTH  multiplicand (rs1 data).
- op_b_i  input  WIDTH  multiplier (rs2 data).
- stall_o  output  1  freeze IF/ID/EX pipeline registers.
- busy_o  output  1  state is RUN.
- done_o  output  1  result_o valid this cycle; single-cycle pulse.
- result_o  output  WIDTH  low WIDTH bits of op_a*op_b, registered.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; acc, mcand, mplier and cnt are 0; result_o=0; done_o=0. busy_o and stall_o read 0 while reset is held.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req_i=1 and flush_i=0, capture mcand=op_a_i, mplier=op_b_i, acc=0, cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per cycle:
  - If mplier[0]=1, acc <= acc + mcand (mod 2^WIDTH).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - Leave RUN after the step with cnt==WIDTH-1. On that edge go to DONE and load result_o with the final accumulated value.
- DONE: done_o=1 for exactly this cycle; always return to IDLE next edge.
- req_i is ignored in DONE. A back-to-back mul is accepted in the following IDLE cycle.
- stall_o is combinational: (IDLE & req_i & ~flush_i) | RUN. It is 0 in DONE so EX/MEM latches result_o on the done_o edge.
- busy_o = (state==RUN).
- Latency (full mode): request accepted at edge T. RUN occupies cycles T..T+WIDTH-1. DONE is the cycle after edge T+WIDTH. The pipeline stalls for WIDTH+1 cycles, counting the request cycle.
- Arithmetic: unsigned shift-add. The low WIDTH bits are identical for signed and unsigned operands, so no sign handling is needed. Overflow bits are discarded.
- result_o holds its value until the next DONE entry. It is unchanged by flush and cleared only by reset.
- flush_i in RUN: return to IDLE next edge; no DONE, no done_o, result_o unchanged.
- flush_i in DONE: done_o still pulses; DONE returns to IDLE as normal.
- flush_i and req_i together in IDLE: no capture; stall_o=0.
- Operand changes on op_a_i/op_b_i after capture have no effect.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs at reset values; no done_o.

Optional Feature:
- Macro: MUL_SEQ_EARLY_TERM_EN.
- Defined: RUN exits to DONE after any step whose next mplier value (mplier>>1) is zero, or when cnt==WIDTH-1, whichever comes first. op_b=0 or op_b=1 takes 1 RUN cycle; op_b=2^k takes k+1 RUN cycles. Products are identical to full mode.
- Undefined: always exactly WIDTH RUN cycles regardless of operand values.

Test Plan:
- Reset, then req_i with op_a=3, op_b=5 → stall_o high for 33 cycles (full mode); done_o pulses once; result_o=15; stall_o=0 in the done cycle.
- op_a=0xFFFFFFFF, op_b=2 → result_o=0xFFFFFFFE. op_a=0x00010000, op_b=0x00010000 → result_o=0x00000000 (overflow discarded).
- Back-to-back requests with req_i held across done: 7*6 then 0x1234*0x10 → done_o pulses twice with result_o=42 then 0x12340. The second request is accepted in the IDLE cycle after DONE.
- flush_i pulsed at RUN cycle 10 of 100*100 → back to IDLE, no done_o, result_o keeps its previous value, stall_o=0 the next cycle.
- rst_i asserted asynchronously mid-RUN (between clock edges) → outputs drop to reset values immediately. A new 9*9 afterwards → result_o=81.
- With MUL_SEQ_EARLY_TERM_EN defined: op_b=0 → 1 RUN cycle, result 0. op_b=8, op_a=5 → 4 RUN cycles, result 40. op_b=0x80000000, op_a=1 → 32 RUN cycles, result 0x80000000.
